// File: rtl/tff_drv_pkg.sv
// Shared types and default timing for the TFF toggle driver chain.
// Counter widths are fixed here so the debounce and FSM stages agree.
package tff_drv_pkg;

    localparam int DB_W      = 16;
    localparam int TC_W      = 24;
    localparam int DEF_CNT_W = 8;

    localparam logic [DB_W-1:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
    localparam logic [TC_W-1:0] DEF_HOLD_CYCLES     = 24'd5000000;
    localparam logic [TC_W-1:0] DEF_REPEAT_CYCLES   = 24'd2500000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        REPEAT = 2'd2
    } drv_state_e;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce filter.
// Latency: level flips DEBOUNCE_CYCLES+1 edges after a stable input change; no backpressure.
module debounce_sync
    import tff_drv_pkg::*;
#(
    parameter logic [DB_W-1:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_IN,
    output logic BTN_LEVEL
);

    localparam logic [DB_W-1:0] DB_LAST = DEBOUNCE_CYCLES - 16'd1;

    logic            s1_q;
    logic            s2_q;
    logic            level_q;
    logic            level_d;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    // Any return of s2 to the current level restarts the count from zero.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= BTN_IN;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BTN_LEVEL = level_q;

endmodule

// File: rtl/tff_toggle_driver.sv
// Turns a raw button into a single-cycle T strobe (press, then optional auto-repeat) with a pulse counter.
// Latency: T_PULSE high in the cycle after edge DEBOUNCE_CYCLES+2; no backpressure, strobe is fire-and-forget.
module tff_toggle_driver
    import tff_drv_pkg::*;
#(
    parameter logic [DB_W-1:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [TC_W-1:0] HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter logic [TC_W-1:0] REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int              CNT_W           = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN_IN,
    input  logic             REPEAT_EN,
    output logic             T_PULSE,
    output logic             BTN_LEVEL,
    output logic [CNT_W-1:0] PULSE_CNT
);

    localparam logic [TC_W-1:0] HOLD_LAST = HOLD_CYCLES - 24'd1;
    localparam logic [TC_W-1:0] REP_LAST  = REPEAT_CYCLES - 24'd1;

    logic             btn_level;
    drv_state_e       state_q;
    drv_state_e       state_d;
    logic [TC_W-1:0]  tc_q;
    logic [TC_W-1:0]  tc_d;
    logic             pulse_q;
    logic             pulse_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    debounce_sync #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK       (CLK),
        .RST       (RST),
        .BTN_IN    (BTN_IN),
        .BTN_LEVEL (btn_level)
    );

    // Release is tested before any expiry so a coincident release never pulses.
    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_level) begin
                    state_d = ARMED;
                    tc_d    = '0;
                    pulse_d = 1'b1;
                end
            end
            ARMED: begin
                if (!btn_level) begin
                    state_d = IDLE;
                    tc_d    = '0;
                end else if (tc_q == HOLD_LAST) begin
                    if (REPEAT_EN) begin
                        state_d = REPEAT;
                        tc_d    = '0;
                        pulse_d = 1'b1;
                    end
                end else begin
                    tc_d = tc_q + TC_W'(1);
                end
            end
            REPEAT: begin
                if (!btn_level || !REPEAT_EN) begin
                    state_d = btn_level ? ARMED : IDLE;
                    tc_d    = '0;
                end else if (tc_q == REP_LAST) begin
                    pulse_d = 1'b1;
                    tc_d    = '0;
                end else begin
                    tc_d = tc_q + TC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tc_d    = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pulse_d) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            tc_q    <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign T_PULSE   = pulse_q;
    assign BTN_LEVEL = btn_level;
    assign PULSE_CNT = cnt_q;

endmodule

// File: tb/tb_tff_toggle_driver.sv
// Scoreboard bench: stimulus pushes the expected strobe cycle and count, a negedge monitor pops on every T_PULSE.
module tb_tff_toggle_driver;

    logic       CLK = 1'b0;
    logic       RST;
    logic       BTN_IN;
    logic       REPEAT_EN;
    logic       T_PULSE;
    logic       BTN_LEVEL;
    logic [7:0] PULSE_CNT;

    int         cyc    = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_cnt;
    int         offs[6];

    typedef struct {
        int         at;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    tff_toggle_driver #(
        .DEBOUNCE_CYCLES (16'd4),
        .HOLD_CYCLES     (24'd20),
        .REPEAT_CYCLES   (24'd8),
        .CNT_W           (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .BTN_IN    (BTN_IN),
        .REPEAT_EN (REPEAT_EN),
        .T_PULSE   (T_PULSE),
        .BTN_LEVEL (BTN_LEVEL),
        .PULSE_CNT (PULSE_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int at);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.at    = at;
        e.cnt   = exp_cnt;
        sb.push_back(e);
    endtask

    // Edge 0 is the first edge after BTN_IN rises; offs[] holds expected strobe edges relative to it.
    task automatic press(input int hold, input int npulse);
        int base;
        BTN_IN = 1'b1;
        base   = cyc + 1;
        for (int i = 0; i < npulse; i++) push(base + offs[i]);
        tick(hold);
        BTN_IN = 1'b0;
        tick(20);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (T_PULSE === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d cnt=%0d", cyc, PULSE_CNT);
            end else begin
                e = sb.pop_front();
                if (cyc != e.at || PULSE_CNT !== e.cnt) begin
                    errors++;
                    $display("FAIL pulse got cyc=%0d cnt=%0d want cyc=%0d cnt=%0d",
                             cyc, PULSE_CNT, e.at, e.cnt);
                end
            end
        end
    end

    initial begin
        int base;
        exp_cnt   = 8'd0;
        RST       = 1'b1;
        BTN_IN    = 1'b1;
        REPEAT_EN = 1'b0;

        // 1: reset with button held, then full debounce after release of RST
        for (int i = 0; i < 2; i++) begin
            tick(1);
            check("rst_tpulse", int'(T_PULSE), 0);
            check("rst_level", int'(BTN_LEVEL), 0);
            check("rst_cnt", int'(PULSE_CNT), 0);
        end
        RST  = 1'b0;
        base = cyc + 1;
        push(base + 6);
        tick(30);
        BTN_IN = 1'b0;
        tick(20);

        // 2: clean press, repeat disabled, held past the hold time
        BTN_IN = 1'b1;
        base   = cyc + 1;
        push(base + 6);
        tick(5);
        check("level_before_edge5", int'(BTN_LEVEL), 0);
        tick(1);
        check("level_at_edge5", int'(BTN_LEVEL), 1);
        tick(24);
        BTN_IN = 1'b0;
        tick(20);
        check("level_released", int'(BTN_LEVEL), 0);
        check("cnt_clean", int'(PULSE_CNT), 2);

        // 3: bouncing input never reaches the threshold
        for (int k = 0; k < 4; k++) begin
            BTN_IN = (k % 2 == 0) ? 1'b1 : 1'b0;
            for (int j = 0; j < 2; j++) begin
                tick(1);
                check("bounce_level", int'(BTN_LEVEL), 0);
            end
        end
        BTN_IN = 1'b1;
        base   = cyc + 1;
        push(base + 6);
        tick(5);
        check("bounce_settle_level", int'(BTN_LEVEL), 0);
        tick(25);
        BTN_IN = 1'b0;
        tick(20);

        // 4: auto-repeat, release lands between repeat ticks
        REPEAT_EN = 1'b1;
        offs = '{6, 26, 34, 42, 50, 0};
        press(50, 5);
        check("cnt_repeat", int'(PULSE_CNT), 8);

        // 5: release reaches the FSM on the same edge the repeat timer expires
        offs = '{6, 26, 34, 0, 0, 0};
        press(36, 3);
        REPEAT_EN = 1'b0;
        offs = '{6, 0, 0, 0, 0, 0};
        press(10, 1);
        check("cnt_after_coincide", int'(PULSE_CNT), 12);

        // 6: 256 strobes wrap the counter, then reset lands mid-repeat
        RST = 1'b1;
        tick(1);
        RST       = 1'b0;
        exp_cnt   = 8'd0;
        REPEAT_EN = 1'b1;
        BTN_IN    = 1'b1;
        base      = cyc + 1;
        push(base + 6);
        push(base + 26);
        for (int k = 1; k <= 254; k++) push(base + 26 + 8 * k);
        tick(2060);
        check("cnt_wrap", int'(PULSE_CNT), 0);
        RST = 1'b1;
        tick(1);
        check("midrep_rst_tpulse", int'(T_PULSE), 0);
        check("midrep_rst_level", int'(BTN_LEVEL), 0);
        check("midrep_rst_cnt", int'(PULSE_CNT), 0);
        RST     = 1'b0;
        exp_cnt = 8'd0;
        base    = cyc + 1;
        push(base + 6);
        tick(5);
        check("redebounce_level", int'(BTN_LEVEL), 0);
        tick(10);
        BTN_IN = 1'b0;
        tick(20);
        check("cnt_after_rst", int'(PULSE_CNT), 1);

        tick(5);
        check("missing_pulses", sb.size(), 0);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            $display("FAIL missing_pulse want cyc=%0d cnt=%0d", e.at, e.cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
